// File: rtl/debounce_pkg.sv
// Shared types and default timing for the stopwatch button front-end.
// Channel FSM encoding plus the counter-width helper used by every channel.
package debounce_pkg;

    typedef enum logic [1:0] {
        ST_IDLE         = 2'b00,
        ST_PRESS_WAIT   = 2'b01,
        ST_PRESSED      = 2'b10,
        ST_RELEASE_WAIT = 2'b11
    } btn_state_e;

    // 10 ms debounce, 500 ms first repeat, 200 ms repeat interval at 100 MHz
    localparam int unsigned DEBOUNCE_CYCLES_DEF = 1_000_000;
    localparam int unsigned REPEAT_DELAY_DEF    = 50_000_000;
    localparam int unsigned REPEAT_PERIOD_DEF   = 20_000_000;

    function automatic int unsigned cnt_width(
        input int unsigned debounce_cycles,
        input int unsigned repeat_delay,
        input int unsigned repeat_period
    );
        int unsigned m;
        m = debounce_cycles;
        if (repeat_delay > m)  m = repeat_delay;
        if (repeat_period > m) m = repeat_period;
        return $clog2(m + 1);
    endfunction

endpackage

// File: rtl/debounce_channel.sv
// One button channel: 2-FF synchroniser, debounce FSM with stability counter, press/release strobes.
// Optional auto-repeat of the press strobe while held, enabled by `BTN_AUTOREPEAT_EN.
module debounce_channel
    import debounce_pkg::*;
#(
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic clk100_i,
    input  logic rstn_i,
    input  logic btn_n_i,
    output logic btn_clean_n_o,
    output logic btn_press_o,
    output logic btn_release_o
);

    localparam int unsigned CNT_W = cnt_width(DEBOUNCE_CYCLES, REPEAT_DELAY, REPEAT_PERIOD);
    localparam logic [CNT_W-1:0] DB_LAST = CNT_W'(DEBOUNCE_CYCLES - 1);
    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             s;
    btn_state_e       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic             clean_n_q, clean_n_d;
    logic             press_q, press_d;
    logic             release_q, release_d;
    logic             rpt_fire;

    assign s = sync_q[1];

`ifdef BTN_AUTOREPEAT_EN
    localparam logic [CNT_W-1:0] RD_LAST = CNT_W'(REPEAT_DELAY - 1);
    localparam logic [CNT_W-1:0] RP_LAST = CNT_W'(REPEAT_PERIOD - 1);

    logic [CNT_W-1:0] rpt_cnt_q, rpt_cnt_d;
    logic             rpt_armed_q, rpt_armed_d;

    // armed = first (long) delay already elapsed, later strobes use the period
    always_comb begin
        rpt_cnt_d   = '0;
        rpt_armed_d = 1'b0;
        rpt_fire    = 1'b0;
        if (state_q == ST_PRESSED && !s) begin
            rpt_armed_d = rpt_armed_q;
            if (rpt_cnt_q == (rpt_armed_q ? RP_LAST : RD_LAST)) begin
                rpt_fire    = 1'b1;
                rpt_armed_d = 1'b1;
            end else begin
                rpt_cnt_d = (rpt_cnt_q == CNT_MAX) ? rpt_cnt_q : rpt_cnt_q + CNT_ONE;
            end
        end
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            rpt_cnt_q   <= '0;
            rpt_armed_q <= 1'b0;
        end else begin
            rpt_cnt_q   <= rpt_cnt_d;
            rpt_armed_q <= rpt_armed_d;
        end
    end
`else
    assign rpt_fire = 1'b0;
`endif

    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        clean_n_d = clean_n_q;
        press_d   = rpt_fire;
        release_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!s) begin
                    state_d = ST_PRESS_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_PRESS_WAIT: begin
                if (s) begin
                    state_d = ST_IDLE;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_PRESSED;
                    cnt_d     = '0;
                    clean_n_d = 1'b0;
                    press_d   = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            ST_PRESSED: begin
                if (s) begin
                    state_d = ST_RELEASE_WAIT;
                    cnt_d   = CNT_ONE;
                end
            end
            ST_RELEASE_WAIT: begin
                if (!s) begin
                    state_d = ST_PRESSED;
                    cnt_d   = '0;
                end else if (cnt_q == DB_LAST) begin
                    state_d   = ST_IDLE;
                    cnt_d     = '0;
                    clean_n_d = 1'b1;
                    release_d = 1'b1;
                end else begin
                    cnt_d = (cnt_q == CNT_MAX) ? cnt_q : cnt_q + CNT_ONE;
                end
            end
            default: begin
                state_d = ST_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    always_ff @(posedge clk100_i or negedge rstn_i) begin
        if (!rstn_i) begin
            sync_q    <= 2'b11;
            state_q   <= ST_IDLE;
            cnt_q     <= '0;
            clean_n_q <= 1'b1;
            press_q   <= 1'b0;
            release_q <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], btn_n_i};
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            clean_n_q <= clean_n_d;
            press_q   <= press_d;
            release_q <= release_d;
        end
    end

    assign btn_clean_n_o = clean_n_q;
    assign btn_press_o   = press_q;
    assign btn_release_o = release_q;

endmodule

// File: rtl/button_debouncer.sv
// Stopwatch button front-end: NUM_BTN independent debounce channels (start/stop, set, change).
// Auto-repeat of press strobes is enabled by defining `BTN_AUTOREPEAT_EN.
module button_debouncer
    import debounce_pkg::*;
#(
    parameter int unsigned NUM_BTN         = 3,
    parameter int unsigned DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF,
    parameter int unsigned REPEAT_DELAY    = REPEAT_DELAY_DEF,
    parameter int unsigned REPEAT_PERIOD   = REPEAT_PERIOD_DEF
) (
    input  logic               clk100_i,
    input  logic               rstn_i,
    input  logic [NUM_BTN-1:0] btn_n_i,
    output logic [NUM_BTN-1:0] btn_clean_n_o,
    output logic [NUM_BTN-1:0] btn_press_o,
    output logic [NUM_BTN-1:0] btn_release_o
);

    if (DEBOUNCE_CYCLES < 2) begin : g_cfg_check
        $error("button_debouncer: DEBOUNCE_CYCLES must be at least 2");
    end

    for (genvar i = 0; i < NUM_BTN; i++) begin : g_ch
        debounce_channel #(
            .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES),
            .REPEAT_DELAY    (REPEAT_DELAY),
            .REPEAT_PERIOD   (REPEAT_PERIOD)
        ) u_ch (
            .clk100_i      (clk100_i),
            .rstn_i        (rstn_i),
            .btn_n_i       (btn_n_i[i]),
            .btn_clean_n_o (btn_clean_n_o[i]),
            .btn_press_o   (btn_press_o[i]),
            .btn_release_o (btn_release_o[i])
        );
    end

endmodule

// File: tb/tb_button_debouncer.sv
// Directed bench for button_debouncer with DEBOUNCE_CYCLES=4, REPEAT_DELAY=8, REPEAT_PERIOD=3.
// Strobes are logged with the index of the clock edge that registered them.
module tb_button_debouncer;

    logic       clk100_i = 1'b0;
    logic       rstn_i;
    logic [2:0] btn_n_i;
    logic [2:0] btn_clean_n_o;
    logic [2:0] btn_press_o;
    logic [2:0] btn_release_o;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    int press_n [3];
    int press_at[3][8];
    int rel_n   [3];
    int rel_at  [3][8];

    button_debouncer #(
        .NUM_BTN         (3),
        .DEBOUNCE_CYCLES (4),
        .REPEAT_DELAY    (8),
        .REPEAT_PERIOD   (3)
    ) dut (
        .clk100_i      (clk100_i),
        .rstn_i        (rstn_i),
        .btn_n_i       (btn_n_i),
        .btn_clean_n_o (btn_clean_n_o),
        .btn_press_o   (btn_press_o),
        .btn_release_o (btn_release_o)
    );

    always #5 clk100_i = ~clk100_i;

    always @(posedge clk100_i) cyc++;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", tag, got, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk100_i);
    endtask

    task automatic clear_logs();
        for (int i = 0; i < 3; i++) begin
            press_n[i] = 0;
            rel_n[i]   = 0;
        end
    endtask

    // strobe logger; press and release must never coincide on a channel
    always @(negedge clk100_i) begin
        for (int i = 0; i < 3; i++) begin
            if (btn_press_o[i]) begin
                if (press_n[i] < 8) press_at[i][press_n[i]] = cyc;
                press_n[i]++;
            end
            if (btn_release_o[i]) begin
                if (rel_n[i] < 8) rel_at[i][rel_n[i]] = cyc;
                rel_n[i]++;
            end
        end
        if (rstn_i === 1'b1) check("excl", {29'd0, btn_press_o & btn_release_o}, 0);
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no finish expected finish");
        $fatal(1, "timeout");
    end

    initial begin
        int c;
        int e;
        int exp_press[5];
        int exp_n;

        clear_logs();
        btn_n_i = 3'b111;
        rstn_i  = 1'b0;
        tick(2);
        check("rst_clean", btn_clean_n_o, 3'b111);
        check("rst_press", btn_press_o, 3'b000);
        check("rst_release", btn_release_o, 3'b000);
        rstn_i = 1'b1;
        tick(3);

        // clean press on channel 1: first sample at c+1, strobe at c+6
        clear_logs();
        c = cyc;
        btn_n_i[1] = 1'b0;
        tick(5);
        check("p1_pre_clean", btn_clean_n_o, 3'b111);
        check("p1_pre_press", btn_press_o, 3'b000);
        tick(1);
        check("p1_press", btn_press_o, 3'b010);
        check("p1_clean", btn_clean_n_o, 3'b101);
        tick(4);
        btn_n_i[1] = 1'b1;
        tick(8);
        check("p1_press_n", press_n[1], 1);
        check("p1_press_at", press_at[1][0], c + 6);
        check("p1_rel_n", rel_n[1], 1);
        check("p1_rel_at", rel_at[1][0], c + 16);
        check("p1_others", press_n[0] + press_n[2] + rel_n[0] + rel_n[2], 0);
        check("p1_clean_after", btn_clean_n_o, 3'b111);

        // bounce on channel 0: low 3, high 1, low 8
        clear_logs();
        c = cyc;
        btn_n_i[0] = 1'b0;
        tick(3);
        btn_n_i[0] = 1'b1;
        tick(1);
        btn_n_i[0] = 1'b0;
        tick(8);
        btn_n_i[0] = 1'b1;
        tick(8);
        check("b0_press_n", press_n[0], 1);
        check("b0_press_at", press_at[0][0], c + 10);
        check("b0_rel_n", rel_n[0], 1);
        check("b0_rel_at", rel_at[0][0], c + 18);

        // glitch on channel 2: three samples only
        clear_logs();
        btn_n_i[2] = 1'b0;
        tick(3);
        btn_n_i[2] = 1'b1;
        tick(2);
        check("g2_clean_mid", btn_clean_n_o, 3'b111);
        tick(6);
        check("g2_press_n", press_n[2], 0);
        check("g2_rel_n", rel_n[2], 0);
        check("g2_clean", btn_clean_n_o, 3'b111);

        // all three channels at once
        clear_logs();
        c = cyc;
        btn_n_i = 3'b000;
        tick(6);
        check("sim_press", btn_press_o, 3'b111);
        check("sim_clean", btn_clean_n_o, 3'b000);
        tick(1);
        check("sim_press_width", btn_press_o, 3'b000);
        btn_n_i = 3'b111;
        tick(8);
        for (int i = 0; i < 3; i++) begin
            check($sformatf("sim_press_n%0d", i), press_n[i], 1);
            check($sformatf("sim_rel_at%0d", i), rel_at[i][0], c + 13);
        end

        // reset while channel 1 is mid-debounce (cnt=2)
        clear_logs();
        c = cyc;
        btn_n_i[1] = 1'b0;
        tick(4);
        rstn_i = 1'b0;
        tick(1);
        check("rr_clean", btn_clean_n_o, 3'b111);
        check("rr_press_n_before", press_n[1], 0);
        rstn_i = 1'b1;
        tick(8);
        check("rr_press_n", press_n[1], 1);
        check("rr_press_at", press_at[1][0], c + 11);
        btn_n_i[1] = 1'b1;
        tick(8);
        check("rr_rel_n", rel_n[1], 1);

        // long hold on channel 2: accept at e, leaves PRESSED before e+20
        clear_logs();
        c = cyc;
        e = c + 6;
        btn_n_i[2] = 1'b0;
        tick(23);
        btn_n_i[2] = 1'b1;
        tick(8);
`ifdef BTN_AUTOREPEAT_EN
        exp_press = '{e, e + 8, e + 11, e + 14, e + 17};
        exp_n = 5;
`else
        exp_press = '{e, 0, 0, 0, 0};
        exp_n = 1;
`endif
        check("h2_press_n", press_n[2], exp_n);
        for (int i = 0; i < 5; i++) begin
            if (i < exp_n) check($sformatf("h2_press_at%0d", i), press_at[2][i], exp_press[i]);
        end
        check("h2_rel_n", rel_n[2], 1);
        check("h2_rel_at", rel_at[2][0], e + 23);
        check("h2_clean", btn_clean_n_o, 3'b111);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
